seg_scroll_n: RTL and testbench
===============================

# seg_scroll_n

Parametrised N-digit scrolling display engine for the UART receive path. Accepts ASCII bytes from the mode controller, converts them to digit codes, buffers them, and shifts them across `DIGITS` seven-segment positions at a selectable rate. It supports one-shot or looping scroll, blanking, overflow flagging and a synchronous clean. It sits between the RX mode controller and the per-digit DEC2SEG decoders. It replaces the fixed three-digit FIFO, asc_to_dec and scroller chain.

## Interface
Parameters:
- `DIGITS`, 3: number of display positions (≥1).
- `DEPTH`, 16: buffer entries, power of two, ≥2.
- `DIV_BASE`, 12_500_000: clk cycles per step at rate 0.

Ports:
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `i_wr_en` in 1: write strobe, one byte per cycle.
- `i_data` in 8: ASCII byte.
- `i_rate` in 2: step period = `DIV_BASE << i_rate` cycles.
- `i_loop` in 1: 0 = one-shot, 1 = recirculate.
- `i_clean` in 1: synchronous clear.
- `o_digits` out 4*DIGITS: digit codes; [3:0] is the rightmost digit.
- `o_blank` out DIGITS: per-digit blank flag, 1 = dark.
- `o_count` out $clog2(DEPTH)+1: buffer occupancy.
- `o_full`, `o_empty` out 1 each: buffer status.
- `o_overflow` out 1: sticky; set when a write is dropped.
- `o_start` out 1: one-cycle pulse when scrolling begins.
- `o_step` out 1: one-cycle pulse on every shift.

## Operation
- Write conversion: each entry is 5 bits, {blank, nibble}.
  - '0'–'9' map to {0, 0–9}.
  - Any other byte maps to {1, 0}. It is still stored and occupies a slot.
- Full buffer: a write while `o_full` is dropped, and `o_overflow` is set.
- FSM states are IDLE, RUN, FLUSH.
  - IDLE → RUN when `o_empty`=0. `o_start` pulses for one cycle. The divider is zeroed.
  - RUN, on each step tick:
    - All digits shift one position left. The leftmost digit is discarded.
    - The head entry is popped into the rightmost digit.
    - If `i_loop`=1, the popped entry is also written back to the tail.
  - RUN → FLUSH when a tick finds the buffer empty. A blank enters the display.
  - FLUSH: each tick shifts in a blank. After `DIGITS` consecutive blank shifts the FSM returns to IDLE with the display fully dark.
  - A write during FLUSH returns the FSM to RUN. The next tick pops the new entry.
- Loop mode: occupancy is constant while looping. The scroll repeats until `i_clean` or until `i_loop` is deasserted. After deassertion the remaining entries drain one-shot.
- `i_clean` has priority over everything. It clears:
  - the buffer pointers and count,
  - the display (all blank),
  - the divider,
  - `o_overflow`,
  - the FSM, which goes to IDLE.
  A write in the same cycle as `i_clean` is discarded.

## Timing
- Reset values: `o_digits`=0, `o_blank`=all 1, `o_count`=0, `o_empty`=1, `o_full`=0, `o_overflow`=0, `o_start`=0, `o_step`=0, FSM=IDLE, divider=0.
- Write to status: `o_count`/`o_empty`/`o_full` update the cycle after the write.
- Start latency: `o_start` pulses the cycle after `o_empty` falls.
- First step: the first shift occurs `DIV_BASE<<i_rate` cycles after `o_start`.
- Shift visibility: `o_digits`/`o_blank` update in the same cycle `o_step` is high (registered together).
- Divider terminal: `(DIV_BASE<<i_rate)-1`. On a rate change, if the count is already ≥ the new terminal, the tick fires on the next cycle and the count restarts at 0.
- Simultaneous write and one-shot pop: both occur; occupancy is unchanged.
- Simultaneous write and loop pop: two tail writes are needed. The step is postponed until the first cycle without `i_wr_en`, so `o_step` slips by one or more cycles. No data is lost.
- Reset mid-operation: outputs return to their reset values immediately (asynchronous).

## Configuration
- `SEG_SCROLL_HEX_EN` defined:
  - 'A'–'F' and 'a'–'f' map to {0, 10–15}.
  - '-' maps to {0, 4'hE} as a dash code for the decoders.
- Not defined: those bytes map to blank {1, 0}.
- All other behaviour is identical in both builds.

## Test plan
All scenarios use DIGITS=3, DEPTH=4, DIV_BASE=4.
- Basic scroll: write "123", i_rate=0, i_loop=0.
  - `o_start` pulses once; steps occur every 4 cycles.
  - Rightmost-first digit sequence: 1 → 21 → 321, then three blank shifts.
  - Finish in IDLE with `o_blank`=3'b111.
- Overflow: write "12345" on consecutive cycles with no step.
  - `o_count`=4, `o_full`=1, `o_overflow`=1; '5' is absent from the scroll.
  - `i_clean` clears `o_overflow` and `o_count`.
- Loop: write "78", i_loop=1.
  - Display cycles ...7,8,7,8... indefinitely; `o_count` stays 2.
  - Deassert i_loop: drains to dark within 5 steps.
- Loop write collision: with i_loop=1, hold i_wr_en high on a tick cycle.
  - `o_step` is delayed one cycle; `o_count` rises by exactly 1; no entry is lost.
- Rate change: at divider count 10 with i_rate=2 (terminal 15), switch to i_rate=0.
  - The tick fires on the next cycle; subsequent steps are 4 cycles apart.
- Hex build: write "A-" with `SEG_SCROLL_HEX_EN`.
  - Codes are 4'hA and 4'hE with blank=0.
  - Without the macro, both entries are blank.

Source files
------------

// File: rtl/seg_scroll_n.sv
// seg_scroll_n: ASCII-fed N-digit scrolling display engine with loop mode.
// Define SEG_SCROLL_HEX_EN to map A-F/a-f to hex codes and '-' to a dash.
module seg_scroll_n #(
  parameter int DIGITS   = 3,
  parameter int DEPTH    = 16,
  parameter int DIV_BASE = 12_500_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_wr_en,
  input  logic [7:0]                i_data,
  input  logic [1:0]                i_rate,
  input  logic                      i_loop,
  input  logic                      i_clean,
  output logic [4*DIGITS-1:0]       o_digits,
  output logic [DIGITS-1:0]         o_blank,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_full,
  output logic                      o_empty,
  output logic                      o_overflow,
  output logic                      o_start,
  output logic                      o_step
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = $clog2(DIV_BASE) + 4;
  localparam int BW = $clog2(DIGITS + 1);
  localparam int NW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  // Entry format is {blank, nibble}; unknown bytes still take a slot.
  function automatic logic [4:0] conv(input logic [7:0] c);
    logic [4:0] r;
    r = 5'h10;
    unique case (1'b1)
      (c >= 8'h30 && c <= 8'h39): r = {1'b0, c[3:0]};
`ifdef SEG_SCROLL_HEX_EN
      (c >= 8'h41 && c <= 8'h46),
      (c >= 8'h61 && c <= 8'h66): r = {1'b0, c[3:0] + 4'd9};
      (c == 8'h2d): r = 5'h0e;
`endif
      default: r = 5'h10;
    endcase
    return r;
  endfunction

  logic [4:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [DW-1:0] cnt;
  logic [DW-1:0] term;
  logic [BW-1:0] nblank;
  state_t        state;

  logic       tick;
  logic       hold;
  logic       step;
  logic       pop;
  logic       recirc;
  logic       wr_acc;
  logic [4:0] head;
  logic [4:0] wdata;

  assign o_count = count;
  assign o_empty = (count == '0);
  assign o_full  = (count == CW'(DEPTH));

  // A loop pop colliding with a write would need two tail writes,
  // so the step waits with the divider parked at its terminal.
  always_comb begin
    term   = (DW'(DIV_BASE) << i_rate) - DW'(1);
    head   = mem[rd_ptr];
    tick   = (state != IDLE) && (cnt >= term);
    hold   = tick && (state == RUN) && !o_empty && i_loop && i_wr_en;
    step   = tick && !hold && !i_clean;
    pop    = step && (state == RUN) && !o_empty;
    recirc = pop && i_loop;
    wr_acc = i_wr_en && !o_full && !i_clean;
    wdata  = recirc ? head : conv(i_data);
  end

  always_ff @(posedge clk) begin
    if (wr_acc || recirc) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cnt        <= '0;
      nblank     <= '0;
      state      <= IDLE;
      o_digits   <= '0;
      o_blank    <= '1;
      o_overflow <= 1'b0;
      o_start    <= 1'b0;
      o_step     <= 1'b0;
    end else if (i_clean) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      cnt        <= '0;
      nblank     <= '0;
      state      <= IDLE;
      o_digits   <= '0;
      o_blank    <= '1;
      o_overflow <= 1'b0;
      o_start    <= 1'b0;
      o_step     <= 1'b0;
    end else begin
      o_start <= 1'b0;
      o_step  <= step;
      if (i_wr_en && o_full) o_overflow <= 1'b1;
      if (wr_acc || recirc) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(wr_acc) - CW'(pop && !recirc);
      if (step) begin
        o_digits <= (o_digits << 4) | NW'(pop ? head[3:0] : 4'h0);
        o_blank  <= (o_blank << 1) | DIGITS'(pop ? head[4] : 1'b1);
      end
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (!o_empty) begin
            state   <= RUN;
            o_start <= 1'b1;
          end
        end
        RUN: begin
          cnt <= step ? '0 : (hold ? cnt : cnt + 1'b1);
          if (step && o_empty) begin
            nblank <= BW'(1);
            state  <= (DIGITS == 1) ? IDLE : FLUSH;
          end
        end
        FLUSH: begin
          cnt <= step ? '0 : cnt + 1'b1;
          if (!o_empty || wr_acc) begin
            state <= RUN;
          end else if (step) begin
            if (nblank == BW'(DIGITS - 1)) state <= IDLE;
            else nblank <= nblank + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seg_scroll_n.sv
// tb_seg_scroll_n: scoreboard bench for seg_scroll_n (3 digits, depth 4).
// Frames are {o_blank, o_digits}, queued as stimulus is driven.
module tb_seg_scroll_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  data;
  logic [1:0]  rate;
  logic        loop;
  logic        clean;
  logic [11:0] digits;
  logic [2:0]  blank;
  logic [2:0]  count;
  logic        full;
  logic        empty;
  logic        ovf;
  logic        start;
  logic        step;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_evt = 0;
  int gap_exp = 0;
  int starts = 0;

  logic [14:0] exp_q [$];
  logic [2:0]  mb;
  logic [11:0] md;

  seg_scroll_n #(.DIGITS(3), .DEPTH(4), .DIV_BASE(4)) dut (
    .clk        (clk),
    .reset      (rst_n),
    .i_wr_en    (wr_en),
    .i_data     (data),
    .i_rate     (rate),
    .i_loop     (loop),
    .i_clean    (clean),
    .o_digits   (digits),
    .o_blank    (blank),
    .o_count    (count),
    .o_full     (full),
    .o_empty    (empty),
    .o_overflow (ovf),
    .o_start    (start),
    .o_step     (step)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && start) begin
      starts++;
      last_evt = cyc;
    end
    if (step) begin
      if (exp_q.size() == 0) check("step_unexp", step, 0);
      else check("frame", {blank, digits}, exp_q.pop_front());
      if (gap_exp != 0) check("gap", cyc - last_evt, gap_exp);
      last_evt = cyc;
    end
  end

  task automatic model_clear();
    mb = 3'b111;
    md = 12'h000;
  endtask

  task automatic push_e(input logic [4:0] e);
    mb = {mb[1:0], e[4]};
    md = {md[7:0], e[3:0]};
    exp_q.push_back({mb, md});
  endtask

  task automatic push_blanks();
    repeat (3) push_e(5'h10);
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en = 1'b1;
    data  = b;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_clean();
    clean = 1'b1;
    @(negedge clk);
    clean = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_step(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (!step && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("step_seen", step, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    data  = 8'h00;
    rate  = 2'd0;
    loop  = 1'b0;
    clean = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_digits", digits, 12'h000);
    check("rst_blank", blank, 3'b111);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_start", start, 0);
    check("rst_step", step, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // basic one-shot scroll
    starts  = 0;
    gap_exp = 4;
    wr("1");
    check("wr_count", count, 1);
    check("wr_empty", empty, 0);
    wr("2");
    wr("3");
    push_e(5'h01);
    push_e(5'h02);
    push_e(5'h03);
    push_blanks();
    wait_drain(60);
    repeat (20) @(negedge clk);
    check("s1_starts", starts, 1);
    check("s1_blank", blank, 3'b111);
    check("s1_count", count, 0);

    // overflow
    model_clear();
    wr("1");
    wr("2");
    wr("3");
    wr("4");
    wr("5");
    check("ovf_count", count, 4);
    check("ovf_full", full, 1);
    check("ovf_flag", ovf, 1);
    push_e(5'h01);
    push_e(5'h02);
    push_e(5'h03);
    push_e(5'h04);
    push_blanks();
    wait_drain(80);
    repeat (6) @(negedge clk);
    check("ovf_sticky", ovf, 1);
    wr("9");
    wr("9");
    check("pre_clean_cnt", count, 2);
    clean = 1'b1;
    wr("9");
    clean = 1'b0;
    check("clean_count", count, 0);
    check("clean_ovf", ovf, 0);
    @(negedge clk);
    check("clean_wr_drop", count, 0);
    check("clean_empty", empty, 1);

    // loop then drain
    model_clear();
    loop = 1'b1;
    wr("7");
    wr("8");
    push_e(5'h07);
    push_e(5'h08);
    push_e(5'h07);
    push_e(5'h08);
    wait_drain(60);
    check("loop_count", count, 2);
    loop = 1'b0;
    push_e(5'h07);
    push_e(5'h08);
    push_blanks();
    wait_drain(60);
    repeat (10) @(negedge clk);
    check("loop_dark", blank, 3'b111);

    // loop write collision
    do_clean();
    model_clear();
    loop = 1'b1;
    wr("7");
    wr("8");
    push_e(5'h07);
    wait_step(40);
    gap_exp = 0;
    repeat (3) @(negedge clk);
    wr_en = 1'b1;
    data  = "5";
    @(negedge clk);
    wr_en = 1'b0;
    check("slip_hold", step, 0);
    check("slip_count", count, 3);
    push_e(5'h08);
    push_e(5'h07);
    push_e(5'h05);
    push_e(5'h08);
    push_e(5'h07);
    @(negedge clk);
    check("slip_step", step, 1);
    check("slip_count2", count, 3);
    @(negedge clk);
    gap_exp = 4;
    wait_drain(60);
    do_clean();
    loop = 1'b0;
    check("cln_blank", blank, 3'b111);
    check("cln_digits", digits, 12'h000);
    check("cln_count", count, 0);
    model_clear();

    // rate change mid-count
    gap_exp = 0;
    rate = 2'd2;
    wr("1");
    wr("2");
    check("start_lat", start, 1);
    repeat (10) @(negedge clk);
    check("rate_nostep", step, 0);
    rate = 2'd0;
    push_e(5'h01);
    push_e(5'h02);
    push_blanks();
    @(negedge clk);
    check("rate_tick", step, 1);
    @(negedge clk);
    gap_exp = 4;
    wait_drain(60);
    check("rate_dark", blank, 3'b111);

    // hex characters
    model_clear();
    wr("A");
    wr("-");
`ifdef SEG_SCROLL_HEX_EN
    push_e(5'h0a);
    push_e(5'h0e);
`else
    push_e(5'h10);
    push_e(5'h10);
`endif
    push_blanks();
    wait_drain(60);
    repeat (4) @(negedge clk);

    // asynchronous reset mid-scroll
    model_clear();
    wr("4");
    wr("6");
    push_e(5'h04);
    wait_step(40);
    #2 rst_n = 1'b0;
    #1;
    check("arst_blank", blank, 3'b111);
    check("arst_digits", digits, 12'h000);
    check("arst_count", count, 0);
    check("arst_empty", empty, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("arst_idle", blank, 3'b111);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
